// File: rtl/mul_share_if.sv
// mul_share_if: requester handshakes, responses and multiplier hookup for the shared multiplier
interface mul_share_if;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_prod, rsp1_prod;
  logic        rsp0_ack, rsp1_ack;
  logic [7:0]  mul_a, mul_b;
  logic [7:0]  mul_prod_low, mul_prod_high;
  logic        busy;
  logic        grant_id;
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ack, rsp1_ack, mul_prod_low, mul_prod_high,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_prod, rsp1_prod,
    output mul_a, mul_b, busy, grant_id
  );
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output rsp0_ack, rsp1_ack, mul_prod_low, mul_prod_high,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_prod, rsp1_prod,
    input  mul_a, mul_b, busy, grant_id
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sequencer sharing one 8x8 multiplier between two requesters
module mul_share_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_last, r_gnt;
  logic [3:0]  r_cnt;
  logic [7:0]  r_mul_a, r_mul_b;
  logic        r_rsp0_valid, r_rsp1_valid;
  logic [15:0] r_rsp0_prod, r_rsp1_prod;
  logic        w_gnt, w_accept, w_done, w_ack;
  // arbitration, handshake qualifiers and next state
  always_comb begin
    w_gnt    = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
    w_accept = (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
    w_done   = (r_state == SETTLE) && (r_cnt == 4'd0);
    w_ack    = (r_state == RESP) && (r_gnt ? bus.rsp1_ack : bus.rsp0_ack);
    w_next   = w_accept ? SETTLE : w_done ? RESP : w_ack ? IDLE : r_state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // operand capture, settle countdown, product capture and response release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last       <= 1'b1;
      r_gnt        <= 1'b0;
      r_cnt        <= 4'd0;
      r_mul_a      <= 8'd0;
      r_mul_b      <= 8'd0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_prod  <= 16'd0;
      r_rsp1_prod  <= 16'd0;
    end else begin
      if (w_accept) begin
        r_mul_a <= w_gnt ? bus.req1_a : bus.req0_a;
        r_mul_b <= w_gnt ? bus.req1_b : bus.req0_b;
        r_gnt   <= w_gnt;
        r_last  <= w_gnt;
        r_cnt   <= 4'(SETTLE_CYCLES - 1);
      end else if (r_state == SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done && !r_gnt) begin
        r_rsp0_prod  <= {bus.mul_prod_high, bus.mul_prod_low};
        r_rsp0_valid <= 1'b1;
      end
      if (w_done && r_gnt) begin
        r_rsp1_prod  <= {bus.mul_prod_high, bus.mul_prod_low};
        r_rsp1_valid <= 1'b1;
      end
      if (w_ack && !r_gnt) r_rsp0_valid <= 1'b0;
      if (w_ack && r_gnt) r_rsp1_valid <= 1'b0;
    end
  end
  assign bus.req0_ready = w_accept && !w_gnt;
  assign bus.req1_ready = w_accept && w_gnt;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_prod  = r_rsp0_prod;
  assign bus.rsp1_prod  = r_rsp1_prod;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.busy       = (r_state != IDLE);
  assign bus.grant_id   = r_gnt;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: randomized and directed scoreboard bench for mul_share_ctrl
module tb_mul_share_ctrl;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_share_if bus();
  mul_share_ctrl #(.SETTLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic       v[2];
  logic [7:0] a[2], b[2];
  logic       ack[2];
  assign bus.req0_valid = v[0];
  assign bus.req1_valid = v[1];
  assign bus.req0_a = a[0];
  assign bus.req0_b = b[0];
  assign bus.req1_a = a[1];
  assign bus.req1_b = b[1];
  assign bus.rsp0_ack = ack[0];
  assign bus.rsp1_ack = ack[1];
  assign {bus.mul_prod_high, bus.mul_prod_low} = 16'(bus.mul_a) * 16'(bus.mul_b);

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] q0[$], q1[$];

  // behavioural model: one operation in flight, round-robin on the last grant
  bit          m_busy = 1'b0, m_last = 1'b1, m_gnt = 1'b0;
  int unsigned m_acc = 0;
  logic [7:0]  m_a = 8'd0, m_b = 8'd0;
  logic [15:0] m_prod[2];
  logic        eg, er0, er1, ev0, ev1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_last = 1'b1; m_gnt = 1'b0; m_a = 8'd0; m_b = 8'd0;
      m_prod[0] = 16'd0; m_prod[1] = 16'd0;
      q0.delete(); q1.delete();
    end else begin
      eg  = (v[0] && v[1]) ? ~m_last : v[1];
      er0 = !m_busy && v[0] && !eg;
      er1 = !m_busy && v[1] && eg;
      ev0 = m_busy && !m_gnt && (cyc >= m_acc + S);
      ev1 = m_busy && m_gnt && (cyc >= m_acc + S);
      check("req0_ready", bus.req0_ready, er0);
      check("req1_ready", bus.req1_ready, er1);
      check("busy", bus.busy, m_busy);
      check("grant_id", bus.grant_id, m_gnt);
      check("mul_a", bus.mul_a, m_a);
      check("mul_b", bus.mul_b, m_b);
      check("rsp0_valid", bus.rsp0_valid, ev0);
      check("rsp1_valid", bus.rsp1_valid, ev1);
      if (ev0) check("rsp0_pending", q0.size(), 1);
      if (ev1) check("rsp1_pending", q1.size(), 1);
      check("rsp0_prod", bus.rsp0_prod, (ev0 && q0.size() > 0) ? q0[0] : m_prod[0]);
      check("rsp1_prod", bus.rsp1_prod, (ev1 && q1.size() > 0) ? q1[0] : m_prod[1]);
      if (ev0 && ack[0] && q0.size() > 0) begin m_prod[0] = q0.pop_front(); m_busy = 1'b0; end
      else if (ev1 && ack[1] && q1.size() > 0) begin m_prod[1] = q1.pop_front(); m_busy = 1'b0; end
      else if (er0 || er1) begin
        m_busy = 1'b1; m_gnt = eg; m_last = eg; m_acc = cyc + 1;
        m_a = eg ? a[1] : a[0];
        m_b = eg ? b[1] : b[0];
      end
    end
  end

  task automatic drive(input int n, input logic [7:0] ta, input logic [7:0] tb_);
    v[n] = 1'b1; a[n] = ta; b[n] = tb_;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n == 0 ? bus.req0_ready : bus.req1_ready) begin
        if (n == 0) q0.push_back(16'(ta) * 16'(tb_));
        else q1.push_back(16'(ta) * 16'(tb_));
        @(posedge clk); #1;
        v[n] = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL accept_timeout req%0d: got no ready expected ready within 400 cycles", n);
    v[n] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #2;
      if (!m_busy && q0.size() == 0 && q1.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL idle_timeout: got busy expected idle within 600 cycles");
  endtask

  task automatic rand_side(input int n);
    for (int i = 0; i < 25; i++) begin
      int k = $urandom_range(0, 3);
      if (k > 0) begin repeat (k) @(posedge clk); #1; end
      drive(n, 8'($urandom), 8'($urandom));
    end
  endtask

  bit rdone = 1'b0;

  initial begin
    v[0] = 0; v[1] = 0; a[0] = 0; a[1] = 0; b[0] = 0; b[1] = 0;
    ack[0] = 1; ack[1] = 1;
    m_prod[0] = 16'd0; m_prod[1] = 16'd0;
    repeat (3) @(posedge clk); #1;
    check("reset_busy", bus.busy, 0);
    check("reset_grant", bus.grant_id, 0);
    check("reset_mul_a", bus.mul_a, 0);
    check("reset_rsp0_valid", bus.rsp0_valid, 0);
    check("reset_rsp1_prod", bus.rsp1_prod, 0);
    // tie from reset: req0 first, then req1
    v[0] = 1; a[0] = 8'd3; b[0] = 8'd5;
    v[1] = 1; a[1] = 8'd7; b[1] = 8'd9;
    rst_n = 1'b1;
    fork
      drive(0, 8'd3, 8'd5);
      drive(1, 8'd7, 8'd9);
    join
    wait_idle();
    check("tie_prod0", bus.rsp0_prod, 16'h000F);
    check("tie_prod1", bus.rsp1_prod, 16'h003F);
    // second tie after req1 served must go to req0
    fork
      drive(0, 8'd2, 8'd4);
      drive(1, 8'd6, 8'd8);
    join
    wait_idle();
    drive(0, 8'h0C, 8'h0D);
    wait_idle();
    check("basic_prod", bus.rsp0_prod, 16'h009C);
    drive(1, 8'hFF, 8'hFF);
    wait_idle();
    check("max_prod", bus.rsp1_prod, 16'hFE01);
    // delayed ack with req1 waiting
    ack[0] = 1'b0;
    fork
      drive(0, 8'h80, 8'h02);
      begin @(posedge clk); #1; drive(1, 8'h11, 8'h22); end
      begin
        repeat (12) @(posedge clk); #1;
        check("held_valid", bus.rsp0_valid, 1);
        check("held_prod", bus.rsp0_prod, 16'h0100);
        ack[0] = 1'b1;
      end
    join
    wait_idle();
    check("after_wait_prod1", bus.rsp1_prod, 16'h0242);
    // spurious ack while idle, then zero operand
    ack[1] = 1'b0;
    @(posedge clk); #1; ack[1] = 1'b1;
    @(posedge clk); #1; ack[1] = 1'b0;
    @(posedge clk); #1;
    drive(0, 8'h00, 8'hAB);
    wait_idle();
    check("zero_prod", bus.rsp0_prod, 16'h0000);
    ack[1] = 1'b1;
    // randomized traffic with random acks
    fork
      begin fork rand_side(0); rand_side(1); join rdone = 1'b1; end
      while (!rdone) begin
        @(posedge clk); #1;
        ack[0] = ($urandom_range(0, 2) != 0);
        ack[1] = ($urandom_range(0, 2) != 0);
      end
    join
    ack[0] = 1'b1; ack[1] = 1'b1;
    wait_idle();
    // reset during SETTLE
    drive(0, 8'h10, 8'h10);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_mul_a", bus.mul_a, 0);
    check("abort_mul_b", bus.mul_b, 0);
    check("abort_rsp0_valid", bus.rsp0_valid, 0);
    check("abort_rsp0_prod", bus.rsp0_prod, 0);
    check("abort_rsp1_prod", bus.rsp1_prod, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    drive(0, 8'h21, 8'h03);
    wait_idle();
    check("post_reset_prod", bus.rsp0_prod, 16'h0063);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
